// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolver: funct3 branch encodings,
// FSM state encoding and flush-counter width.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Wide enough for the largest legal flush length (15).
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage : branch_pkg

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluation from funct3 and the SUB flags.
// A jump overrides funct3 and is always taken and never illegal.
module branch_cond
    import branch_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       is_jump,
    input  logic       zero,
    input  logic       carry,
    input  logic       sign,
    input  logic       overflow,
    output logic       cond,
    output logic       illegal
);

    logic lt_signed;
    assign lt_signed = sign ^ overflow;

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        if (is_jump) begin
            cond = 1'b1;
        end else begin
            case (funct3)
                F3_BEQ:  cond = zero;
                F3_BNE:  cond = !zero;
                F3_BLT:  cond = lt_signed;
                F3_BGE:  cond = !lt_signed;
                F3_BLTU: cond = carry;
                F3_BGEU: cond = !carry;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule : branch_cond

// File: rtl/branch_resolver.sv
// Branch resolver: accepts one request, returns a registered result through a
// valid/ready handshake, then holds flush for FLUSH_CYCLES after a taken branch.
// Optional feature: define BRANCH_MISALIGN_CHECK_EN to add the misaligned output.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  funct3,
    input  logic        is_jump,
    input  logic        zero,
    input  logic        carry,
    input  logic        sign,
    input  logic        overflow,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        taken,
    output logic [31:0] target,
    output logic        illegal,
`ifdef BRANCH_MISALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic        flush
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              taken_q, taken_d;
    logic [31:0]       target_q, target_d;
    logic              illegal_q, illegal_d;
    logic              cond;
    logic              cond_illegal;
    logic [31:0]       sum;

    branch_cond u_cond (
        .funct3   (funct3),
        .is_jump  (is_jump),
        .zero     (zero),
        .carry    (carry),
        .sign     (sign),
        .overflow (overflow),
        .cond     (cond),
        .illegal  (cond_illegal)
    );

    // Modulo-2^32 add: the carry out is intentionally dropped.
    assign sum = pc + imm;

`ifdef BRANCH_MISALIGN_CHECK_EN
    logic misaligned_q, misaligned_d;
    logic misaligned_now;
    assign misaligned_now = cond && (sum[1:0] != 2'b00);
    assign misaligned     = misaligned_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        taken_d   = taken_q;
        target_d  = target_q;
        illegal_d = illegal_q;
`ifdef BRANCH_MISALIGN_CHECK_EN
        misaligned_d = misaligned_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    taken_d   = cond;
                    target_d  = sum;
                    illegal_d = cond_illegal;
`ifdef BRANCH_MISALIGN_CHECK_EN
                    misaligned_d = misaligned_now;
                    if (misaligned_now) begin
                        taken_d = 1'b0;
                    end
`endif
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    state_d = taken_q ? ST_FLUSH : ST_IDLE;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_FLUSH: begin
                // Counter reaching zero marks the last flush cycle.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            taken_q   <= 1'b0;
            target_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            taken_q   <= taken_d;
            target_q  <= target_d;
            illegal_q <= illegal_d;
        end
    end

`ifdef BRANCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`endif

    // All handshake outputs decode the registered state, so they are glitch-free.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_RESP);
    assign flush     = (state_q == ST_FLUSH);
    assign taken     = taken_q;
    assign target    = target_q;
    assign illegal   = illegal_q;

endmodule : branch_resolver

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (FLUSH_CYCLES = 2).
// Define BRANCH_MISALIGN_CHECK_EN to also exercise the misaligned output.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic        is_jump;
    logic        zero;
    logic        carry;
    logic        sign;
    logic        overflow;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic        taken;
    logic [31:0] target;
    logic        illegal;
    logic        flush;
`ifdef BRANCH_MISALIGN_CHECK_EN
    logic        misaligned;
`endif

    int errors = 0;
    int checks = 0;

    branch_resolver #(.FLUSH_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .is_jump   (is_jump),
        .zero      (zero),
        .carry     (carry),
        .sign      (sign),
        .overflow  (overflow),
        .pc        (pc),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .taken     (taken),
        .target    (target),
        .illegal   (illegal),
`ifdef BRANCH_MISALIGN_CHECK_EN
        .misaligned(misaligned),
`endif
        .flush     (flush)
    );

    always #5 clk = ~clk;

    // {in_ready, out_valid, flush, taken, illegal} and the control subset.
    logic [4:0] st;
    logic [2:0] ctl;
    assign st  = {in_ready, out_valid, flush, taken, illegal};
    assign ctl = {in_ready, out_valid, flush};

    typedef struct packed {
        logic [2:0] f3;
        logic       j, z, c, s, o;
        logic       tk, il;
    } vec_t;

    vec_t tbl [9] = '{
        '{3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // BNE z=0
        '{3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // BNE z=1
        '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0},  // BGE s=1 o=0
        '{3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // BGE s=1 o=1
        '{3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // BGEU c=0
        '{3'b111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0},  // BGEU c=1
        '{3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},  // BEQ z=0
        '{3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},  // 011 illegal
        '{3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}   // BLT s=0 o=1
    };

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic j, z, c, s, o,
                         input logic [31:0] p, i);
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_wait in_ready=%b required 1", in_ready);
        end
        funct3 = f3; is_jump = j; zero = z; carry = c; sign = s; overflow = o;
        pc = p; imm = i;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (st !== 5'b10000 || target !== 32'h0) begin
            errors++;
            $display("FAIL reset_values st=%b target=%h required st=10000 target=0", st, target);
        end
`ifdef BRANCH_MISALIGN_CHECK_EN
        checks++;
        if (misaligned !== 1'b0) begin
            errors++;
            $display("FAIL reset_misaligned got=%b required 0", misaligned);
        end
`endif
        #9 rst_n = 1'b1;
        step();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL reset_release ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_beq_flush();
        issue(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h20);
        checks++;
        if (st !== 5'b01010 || target !== 32'h120) begin
            errors++;
            $display("FAIL beq_result st=%b target=%h required 01010 00000120", st, target);
        end
        handshake();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (ctl !== 3'b001) begin
                errors++;
                $display("FAIL beq_flush_cycle%0d ctl=%b required 001", k, ctl);
            end
            step();
        end
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL beq_after_flush ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_blt_not_taken();
        issue(3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'h8);
        checks++;
        if (st !== 5'b01000 || target !== 32'h308) begin
            errors++;
            $display("FAIL blt_result st=%b target=%h required 01000 00000308", st, target);
        end
        handshake();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL blt_idle ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_bltu_wrap();
        issue(3'b110, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20);
        checks++;
        if (st !== 5'b01010 || target !== 32'h10) begin
            errors++;
            $display("FAIL bltu_wrap st=%b target=%h required 01010 00000010", st, target);
        end
        handshake();
        step();
        step();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL bltu_idle ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_illegal_jump();
        issue(3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h400, 32'h10);
        checks++;
        if (st !== 5'b01001 || target !== 32'h410) begin
            errors++;
            $display("FAIL illegal_result st=%b target=%h required 01001 00000410", st, target);
        end
        handshake();
        issue(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h200, 32'h40);
        checks++;
        if (st !== 5'b01010 || target !== 32'h240) begin
            errors++;
            $display("FAIL jump_result st=%b target=%h required 01010 00000240", st, target);
        end
        handshake();
        step();
        step();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL jump_idle ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_stall();
        issue(3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h500, 32'hC);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            funct3 = 3'b010; is_jump = 1'b0; zero = 1'b1; pc = 32'h0; imm = 32'h3;
            step();
            checks++;
            if (st !== 5'b01010 || target !== 32'h50C) begin
                errors++;
                $display("FAIL stall_cycle%0d st=%b target=%h required 01010 0000050c", k, st, target);
            end
        end
        in_valid = 1'b0;
        handshake();
        step();
        step();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL stall_idle ctl=%b required 100", ctl);
        end
    endtask

    task automatic test_cond_table();
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].f3, tbl[i].j, tbl[i].z, tbl[i].c, tbl[i].s, tbl[i].o,
                  32'h1000, 32'(4 * i));
            checks++;
            if (st !== {3'b010, tbl[i].tk, tbl[i].il} || target !== 32'h1000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL cond_vec%0d st=%b target=%h required %b %h", i, st, target,
                         {3'b010, tbl[i].tk, tbl[i].il}, 32'h1000 + 32'(4 * i));
            end
            handshake();
            if (tbl[i].tk) begin
                step();
                step();
            end
            checks++;
            if (ctl !== 3'b100) begin
                errors++;
                $display("FAIL cond_vec%0d_idle ctl=%b required 100", i, ctl);
            end
        end
    endtask

    task automatic test_reset_in_flush();
        issue(3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h600, 32'h10);
        handshake();
        step();
        checks++;
        if (ctl !== 3'b001) begin
            errors++;
            $display("FAIL rstflush_second_cycle ctl=%b required 001", ctl);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (st !== 5'b10000 || target !== 32'h0) begin
            errors++;
            $display("FAIL rstflush_async st=%b target=%h required 10000 0", st, target);
        end
        #3 rst_n = 1'b1;
        step();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL rstflush_release ctl=%b required 100", ctl);
        end
    endtask

`ifdef BRANCH_MISALIGN_CHECK_EN
    task automatic test_misalign();
        issue(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 32'h2);
        checks++;
        if (st !== 5'b01000 || target !== 32'h102 || misaligned !== 1'b1) begin
            errors++;
            $display("FAIL misalign_result st=%b target=%h mis=%b required 01000 00000102 1",
                     st, target, misaligned);
        end
        handshake();
        checks++;
        if (ctl !== 3'b100) begin
            errors++;
            $display("FAIL misalign_no_flush ctl=%b required 100", ctl);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        funct3 = 3'b000; is_jump = 1'b0; zero = 1'b0; carry = 1'b0;
        sign = 1'b0; overflow = 1'b0; pc = 32'h0; imm = 32'h0;
        test_reset();
        test_beq_flush();
        test_blt_not_taken();
        test_bltu_wrap();
        test_illegal_jump();
        test_stall();
        test_cond_table();
        test_reset_in_flush();
`ifdef BRANCH_MISALIGN_CHECK_EN
        test_misalign();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule : tb_branch_resolver
